// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg: shared FSM state type, default sizes and forwarding switch for regfile_mp.
// Build macro: REGFILE_MP_BYPASS_EN selects read-after-write forwarding for same-cycle collisions.
package regfile_mp_pkg;
  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_DEF = 2;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif
endpackage

// File: rtl/regfile_mp_rdport.sv
// regfile_mp_rdport: one registered read port (array mux, write forwarding, r0 mask, output flop).
// Ports: clk/rst clock and async reset; i_state FSM state; i_we/i_wr_addr/i_wr_data write request;
//        i_rd_addr read address; i_mem storage array; o_rd_data registered read data.
// Build macro: REGFILE_MP_BYPASS_EN (via regfile_mp_pkg::BYPASS_EN) enables forwarding.
module regfile_mp_rdport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int ZERO_R0 = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  state_t            i_state,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic [DATA_W-1:0] i_mem [2**ADDR_W],
  output logic [DATA_W-1:0] o_rd_data
);
  logic              w_hit;
  logic              w_zero;
  logic [DATA_W-1:0] w_data;
  // Forwarding only applies to writes the array would actually accept, i.e. in IDLE.
  assign w_hit  = BYPASS_EN && i_state == IDLE && i_we && i_wr_addr == i_rd_addr;
  assign w_zero = i_state == CLEAR || (ZERO_R0 != 0 && i_rd_addr == '0);
  assign w_data = w_zero ? '0 : w_hit ? i_wr_data : i_mem[i_rd_addr];
  always_ff @(posedge clk or posedge rst)
    if (rst) o_rd_data <= '0;
    else o_rd_data <= w_data;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with a self-clearing sweep after reset or on request.
// Ports: clk, rst (async, active-high); rd_addr/rd_data packed per read port (1-cycle latency);
//        we/wr_addr/wr_data write port; clr_req clear pulse; busy high during the clear sweep.
// Build macro: REGFILE_MP_BYPASS_EN selects read-after-write on same-cycle collisions,
//              otherwise reads return the pre-write value.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int NUM_RD  = NUM_RD_DEF,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t            r_state;
  state_t            w_state_nx;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_cnt_nx;
  logic              w_wr_en;
  logic [DATA_W-1:0] r_mem [DEPTH];
  always_comb begin
    w_state_nx = r_state == IDLE ? (clr_req ? CLEAR : IDLE) : (r_clr_cnt == LAST ? IDLE : CLEAR);
    w_cnt_nx   = r_state == CLEAR ? r_clr_cnt + 1'b1 : '0;
  end
  // Reset parks the FSM at the start of a sweep so the array is zeroed without resetting it.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_clr_cnt <= w_cnt_nx;
    end
  assign busy    = r_state == CLEAR;
  assign w_wr_en = r_state == IDLE && we && !(ZERO_R0 != 0 && wr_addr == '0);
  always_ff @(posedge clk)
    if (r_state == CLEAR) r_mem[r_clr_cnt] <= '0;
    else if (w_wr_en) r_mem[wr_addr] <= wr_data;
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_mp_rdport #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .ZERO_R0(ZERO_R0)
    ) u_rdport (
      .clk      (clk),
      .rst      (rst),
      .i_state  (r_state),
      .i_we     (we),
      .i_wr_addr(wr_addr),
      .i_wr_data(wr_data),
      .i_rd_addr(rd_addr[i*ADDR_W +: ADDR_W]),
      .i_mem    (r_mem),
      .o_rd_data(rd_data[i*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: randomized scoreboard bench for regfile_mp against an array-based reference model.
module tb_regfile_mp;
  localparam int DW = 32, AW = 5, NR = 2, DEPTH = 32;
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  typedef struct packed {
    logic [NR*DW-1:0] rd;
    logic             busy;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0, we = 1'b0, clr_req = 1'b0, busy;
  logic [AW-1:0]    wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic [NR*AW-1:0] rd_addr = '0;
  logic [NR*DW-1:0] rd_data;
  exp_t             q[$];
  logic [DW-1:0]    mem [DEPTH];
  int               left = 0;
  int               n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  regfile_mp dut (
    .clk    (clk),
    .rst    (rst),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .we     (we),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .clr_req(clr_req),
    .busy   (busy)
  );
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model of one clock edge: reads see the array before the write (or the forwarded data),
  // entry 0 reads zero, and a clear blanks reads and ignores requests for DEPTH edges.
  task automatic apply(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic c);
    exp_t e;
    logic [AW-1:0] a;
    we = w; wr_addr = wa; wr_data = wd; rd_addr = {a1, a0}; clr_req = c;
    if (left > 0) begin
      e.rd = '0;
      left--;
    end else begin
      for (int p = 0; p < NR; p++) begin
        a = p == 0 ? a0 : a1;
        e.rd[p*DW +: DW] = a == 0 ? '0 : (BYP && w && a == wa) ? wd : mem[a];
      end
      if (w && wa != 0) mem[wa] = wd;
      if (c) begin
        left = DEPTH;
        foreach (mem[k]) mem[k] = '0;
      end
    end
    e.busy = left > 0;
    q.push_back(e);
  endtask
  task automatic step(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic c);
    @(negedge clk);
    apply(w, wa, wd, a0, a1, c);
  endtask
  task automatic idle_rd();
    step(1'b0, '0, '0, AW'($urandom), AW'($urandom), 1'b0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    we = 1'b0; clr_req = 1'b0;
    rst = 1'b1;
    #1;
    check("reset_busy", 128'(busy), 128'(1));
    check("reset_rd_data", 128'(rd_data), 128'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    q.delete();
    left = DEPTH;
    foreach (mem[k]) mem[k] = '0;
    apply(1'b0, '0, '0, AW'($urandom), AW'($urandom), 1'b0);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && q.size() > 0) begin
      e = q.pop_front();
      check("rd_data", 128'(rd_data), 128'(e.rd));
      check("busy", 128'(busy), 128'(e.busy));
    end
  end
  initial begin
    do_reset();
    repeat (DEPTH - 1) idle_rd();
    step(1'b0, '0, '0, 5'd7, 5'd7, 1'b0);
    step(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0);
    step(1'b0, '0, '0, 5'd5, 5'd5, 1'b0);
    step(1'b1, 5'd9, 32'h0000AAAA, 5'd3, 5'd4, 1'b0);
    step(1'b1, 5'd9, 32'h00001234, 5'd9, 5'd5, 1'b0);
    step(1'b0, '0, '0, 5'd9, 5'd9, 1'b0);
    step(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
    step(1'b0, '0, '0, 5'd0, 5'd0, 1'b0);
    for (int r = 1; r < DEPTH; r++) step(1'b1, AW'(r), $urandom | 32'h1, AW'(r - 1), 5'd5, 1'b0);
    step(1'b0, '0, '0, 5'd3, 5'd31, 1'b1);
    for (int k = 0; k < DEPTH; k++)
      step(k == 2, 5'd3, 32'h55, AW'($urandom), 5'd3, k == 10);
    for (int r = 0; r < DEPTH; r += 2) step(1'b0, '0, '0, AW'(r), AW'(r + 1), 1'b0);
    for (int r = 1; r < 8; r++) step(1'b1, AW'(r), $urandom, 5'd0, AW'(r - 1), 1'b0);
    step(1'b0, '0, '0, 5'd1, 5'd2, 1'b1);
    repeat (14) idle_rd();
    do_reset();
    repeat (DEPTH + 2) idle_rd();
    for (int n = 0; n < 600; n++) begin
      logic [AW-1:0] wa;
      wa = AW'($urandom_range(0, 7));
      step($urandom_range(0, 1) == 1, wa, $urandom,
           $urandom_range(0, 3) == 0 ? wa : AW'($urandom_range(0, 7)),
           $urandom_range(0, 3) == 0 ? wa : AW'($urandom),
           $urandom_range(0, 79) == 0);
      if (n == 300) do_reset();
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 128'(q.size()), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
